// File: rtl/rv_cg_pkg.sv
// rv_cg_pkg: shared types and parameter sanity helper for the clock-gate
// enable scheduler (rv_cg_sched) and its per-unit FSM (rv_cg_unit).
package rv_cg_pkg;

  typedef enum logic [1:0] {CG_OFF, CG_WAKE, CG_ON, CG_HOLD} cg_state_e;

  // Legal configuration: 2..16 units, at least one hysteresis cycle and
  // at least one wake cycle.
  function automatic bit cg_params_ok(input int nunits, input int hyst,
                                      input int wake_lat);
    return (nunits >= 2) && (nunits <= 16) && (hyst >= 1) && (wake_lat >= 1);
  endfunction

endpackage

// File: rtl/rv_cg_sched_if.sv
// rv_cg_sched_if: request/status bundle between the functional-unit side
// (master) and the clock-gate scheduler (slave).
//   scan_mode, force_on : global overrides
//   req, busy           : per-unit activity
//   cg_en               : per-unit gate enable to rvclkhdr.en
//   ack                 : per-unit "clock stable"
//   waking              : a wake phase is in flight
interface rv_cg_sched_if #(parameter int NUNITS = 4);
  logic              scan_mode;
  logic              force_on;
  logic [NUNITS-1:0] req;
  logic [NUNITS-1:0] busy;
  logic [NUNITS-1:0] cg_en;
  logic [NUNITS-1:0] ack;
  logic              waking;

  modport master (output scan_mode, force_on, req, busy,
                  input  cg_en, ack, waking);
  modport slave  (input  scan_mode, force_on, req, busy,
                  output cg_en, ack, waking);
endinterface

// File: rtl/rv_cg_unit.sv
// rv_cg_unit: per-unit gating FSM OFF -> WAKE -> ON <-> HOLD -> OFF.
// Ports:
//   clk, rst_l  : clock, synchronous active-low reset
//   grant       : arbiter picked this unit for the next wake phase
//   wake_done   : shared wake counter has reached zero
//   force_on    : debug override, OFF+req goes straight to ON
//   req, busy   : unit activity
//   st_en       : FSM wants the clock (any state but OFF)
//   ack         : registered, clock stable and requested
//   in_wake     : unit is in its wake phase
module rv_cg_unit
  import rv_cg_pkg::*;
#(
  parameter int HYST = 8
) (
  input  logic clk,
  input  logic rst_l,
  input  logic grant,
  input  logic wake_done,
  input  logic force_on,
  input  logic req,
  input  logic busy,
  output logic st_en,
  output logic ack,
  output logic in_wake
);

  localparam int IW = $clog2(HYST + 1);

  cg_state_e       state;
  logic [IW-1:0]   idle_cnt;

  // ack is registered alongside the state: high exactly when the next state
  // is ON and the unit is still requesting.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state    <= CG_OFF;
      idle_cnt <= '0;
      ack      <= 1'b0;
    end else begin
      case (state)
        CG_OFF: begin
          ack <= 1'b0;
          if (req && force_on) begin
            state <= CG_ON;
            ack   <= 1'b1;
          end else if (grant) begin
            state <= CG_WAKE;
          end
        end
        CG_WAKE: begin
          // A dropped req does not abort the wake; ON then applies the idle rule.
          ack <= 1'b0;
          if (wake_done) begin
            state <= CG_ON;
            ack   <= req;
          end
        end
        CG_ON: begin
          if (!req && !busy) begin
            state    <= CG_HOLD;
            idle_cnt <= IW'(HYST - 1);
            ack      <= 1'b0;
          end else begin
            ack <= req;
          end
        end
        CG_HOLD: begin
          ack <= 1'b0;
          if (req || busy) begin
            state <= CG_ON;
            ack   <= req;
          end else if (idle_cnt == '0) begin
            state <= CG_OFF;
          end else begin
            idle_cnt <= idle_cnt - 1'b1;
          end
        end
        default: begin
          state <= CG_OFF;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  assign st_en   = (state != CG_OFF);
  assign in_wake = (state == CG_WAKE);

endmodule

// File: rtl/rv_cg_sched.sv
// rv_cg_sched: clock-gate enable scheduler for NUNITS functional units.
// Holds the shared wake counter, the round-robin wake arbiter and the
// override OR onto cg_en; per-unit sequencing lives in rv_cg_unit.
// Ports:
//   clk    : free-running clock
//   rst_l  : synchronous active-low reset
//   bus    : rv_cg_sched_if slave (scan_mode, force_on, req, busy in;
//            cg_en, ack, waking out)
module rv_cg_sched
  import rv_cg_pkg::*;
#(
  parameter int NUNITS   = 4,
  parameter int HYST     = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_l,
  rv_cg_sched_if.slave  bus
);

  localparam int PW = $clog2(NUNITS);
  localparam int WW = $clog2(WAKE_LAT + 1);

  if (!cg_params_ok(NUNITS, HYST, WAKE_LAT)) begin : g_bad_params
    $error("rv_cg_sched: illegal NUNITS/HYST/WAKE_LAT");
  end

  logic [NUNITS-1:0] st_en;
  logic [NUNITS-1:0] ack;
  logic [NUNITS-1:0] in_wake;
  logic [NUNITS-1:0] cand;
  logic [NUNITS-1:0] grant;
  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     idx;
  logic [PW-1:0]     rr_ptr;
  logic [WW-1:0]     wake_cnt;
  logic              waking;
  logic              wake_done;

  assign waking    = |in_wake;
  assign wake_done = (wake_cnt == '0);

  // Candidates are OFF units asking for a clock. Under force_on those units
  // go straight to ON, so no wake is granted and rr_ptr does not move.
  assign cand = bus.req & ~st_en;

  // Round-robin pick starting at rr_ptr; one grant per cycle and none while
  // a wake is in flight, so a wake ending and a new grant land on
  // consecutive cycles.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    if (!waking && !bus.force_on) begin
      for (int k = 0; k < NUNITS; k++) begin
        idx = PW'((int'(rr_ptr) + k) % NUNITS);
        if (!grant_vld && cand[idx]) begin
          grant_vld  = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = idx;
        end
      end
    end
  end

  // Shared wake counter loads on the grant edge, the same edge the unit
  // enters WAKE; only one wake is ever in flight.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      rr_ptr   <= '0;
      wake_cnt <= '0;
    end else begin
      if (grant_vld) begin
        rr_ptr   <= PW'((int'(grant_idx) + 1) % NUNITS);
        wake_cnt <= WW'(WAKE_LAT - 1);
      end else if (wake_cnt != '0) begin
        wake_cnt <= wake_cnt - 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUNITS; i++) begin : g_unit
    rv_cg_unit #(.HYST(HYST)) u_unit (
      .clk       (clk),
      .rst_l     (rst_l),
      .grant     (grant[i]),
      .wake_done (wake_done),
      .force_on  (bus.force_on),
      .req       (bus.req[i]),
      .busy      (bus.busy[i]),
      .st_en     (st_en[i]),
      .ack       (ack[i]),
      .in_wake   (in_wake[i])
    );
  end

  assign bus.cg_en  = st_en | {NUNITS{bus.scan_mode | bus.force_on}};
  assign bus.ack    = ack;
  assign bus.waking = waking;

endmodule

// File: tb/tb_rv_cg_sched.sv
// tb_rv_cg_sched: table-driven bench for rv_cg_sched (NUNITS=4, HYST=8,
// WAKE_LAT=2) plus hand-written inrush, round-robin and reset sequences.
module tb_rv_cg_sched;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  rv_cg_sched_if #(.NUNITS(N)) bus ();

  rv_cg_sched #(.NUNITS(N), .HYST(8), .WAKE_LAT(2)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic [3:0] req;
    logic [3:0] busy;
    logic       scan;
    logic       frc;
    int         n;
    logic [3:0] cg;
    logic [3:0] ack;
    logic       wk;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input string tag, input logic [3:0] r,
                              input logic [3:0] b, input logic s,
                              input logic f, input int n,
                              input logic [3:0] cg, input logic [3:0] a,
                              input logic w);
    vec_t v;
    v.tag = tag; v.req = r; v.busy = b; v.scan = s; v.frc = f;
    v.n = n; v.cg = cg; v.ack = a; v.wk = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] b,
                       input logic s, input logic f);
    bus.req       = r;
    bus.busy      = b;
    bus.scan_mode = s;
    bus.force_on  = f;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    rst_l = 1'b1;
  endtask

  // Units 0 and 2 request together; first_exp is the unit expected to win
  // the first wake, the other follows 3 cycles later. Then both go idle and
  // must gate after the hysteresis window.
  task automatic run_pair(input string tag, input logic [3:0] first_exp);
    for (int k = 0; k < 7; k++) begin
      drive(4'b0101, 4'b0000, 1'b0, 1'b0);
      #1;
      if (k == 1) chk({tag, "_cg_first"}, bus.cg_en, first_exp);
      if (k == 3) chk({tag, "_ack_first"}, bus.ack, first_exp);
      if (k == 4) chk({tag, "_cg_both"}, bus.cg_en, 4'b0101);
      if (k == 6) chk({tag, "_ack_both"}, bus.ack, 4'b0101);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      drive(4'b0000, 4'b0000, 1'b0, 1'b0);
      #1;
      if (k == 8) chk({tag, "_cg_hold"}, bus.cg_en, 4'b0101);
      if (k == 9) chk({tag, "_cg_off"}, bus.cg_en, 4'b0000);
      tick();
    end
  endtask

  initial begin
    logic [3:0] ea, ec;
    logic       ew;

    // Reset state, including scan_mode forcing cg_en while in reset.
    rst_l = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    bus.scan_mode = 1'b1;
    #1;
    chk("rst_scan_cg", bus.cg_en, 4'b1111);
    chk("rst_ack", bus.ack, 4'b0000);
    chk("rst_waking", {3'b000, bus.waking}, 4'b0000);
    bus.scan_mode = 1'b0;
    #1;
    chk("rst_cg", bus.cg_en, 4'b0000);
    tick();
    rst_l = 1'b1;

    //          tag           req      busy     scan  frc   n   cg       ack      wk
    vt.push_back(mk("idle",    4'b0000, 4'b0000, 1'b0, 1'b0, 3, 4'b0000, 4'b0000, 1'b0));
    vt.push_back(mk("busy_off",4'b0000, 4'b1111, 1'b0, 1'b0, 3, 4'b0000, 4'b0000, 1'b0));
    // single wake on unit 0
    vt.push_back(mk("t1_grant",4'b0001, 4'b0000, 1'b0, 1'b0, 1, 4'b0000, 4'b0000, 1'b0));
    vt.push_back(mk("t1_wake", 4'b0001, 4'b0000, 1'b0, 1'b0, 2, 4'b0001, 4'b0000, 1'b1));
    vt.push_back(mk("t1_on",   4'b0001, 4'b0000, 1'b0, 1'b0, 7, 4'b0001, 4'b0001, 1'b0));
    vt.push_back(mk("t1_drop", 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 4'b0001, 4'b0001, 1'b0));
    vt.push_back(mk("t1_hold", 4'b0000, 4'b0000, 1'b0, 1'b0, 8, 4'b0001, 4'b0000, 1'b0));
    vt.push_back(mk("t1_off",  4'b0000, 4'b0000, 1'b0, 1'b0, 2, 4'b0000, 4'b0000, 1'b0));
    // hysteresis rescue on unit 1
    vt.push_back(mk("t2_grant",4'b0010, 4'b0000, 1'b0, 1'b0, 1, 4'b0000, 4'b0000, 1'b0));
    vt.push_back(mk("t2_wake", 4'b0010, 4'b0000, 1'b0, 1'b0, 2, 4'b0010, 4'b0000, 1'b1));
    vt.push_back(mk("t2_on",   4'b0010, 4'b0000, 1'b0, 1'b0, 1, 4'b0010, 4'b0010, 1'b0));
    vt.push_back(mk("t2_drop", 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 4'b0010, 4'b0010, 1'b0));
    vt.push_back(mk("t2_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 4, 4'b0010, 4'b0000, 1'b0));
    vt.push_back(mk("t2_rereq",4'b0010, 4'b0000, 1'b0, 1'b0, 1, 4'b0010, 4'b0000, 1'b0));
    vt.push_back(mk("t2_reack",4'b0010, 4'b0000, 1'b0, 1'b0, 1, 4'b0010, 4'b0010, 1'b0));
    // busy keeps the clock on
    vt.push_back(mk("t2_bz0",  4'b0000, 4'b0010, 1'b0, 1'b0, 1, 4'b0010, 4'b0010, 1'b0));
    vt.push_back(mk("t2_busy", 4'b0000, 4'b0010, 1'b0, 1'b0, 19,4'b0010, 4'b0000, 1'b0));
    vt.push_back(mk("t2_bhold",4'b0000, 4'b0000, 1'b0, 1'b0, 9, 4'b0010, 4'b0000, 1'b0));
    vt.push_back(mk("t2_boff", 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 4'b0000, 4'b0000, 1'b0));
    // scan override
    vt.push_back(mk("t5_scan", 4'b0000, 4'b0000, 1'b1, 1'b0, 2, 4'b1111, 4'b0000, 1'b0));
    vt.push_back(mk("t5_nscan",4'b0000, 4'b0000, 1'b0, 1'b0, 1, 4'b0000, 4'b0000, 1'b0));
    // force_on: unit 3 skips the wake phase
    vt.push_back(mk("t5_frc",  4'b0000, 4'b0000, 1'b0, 1'b1, 1, 4'b1111, 4'b0000, 1'b0));
    vt.push_back(mk("t5_freq", 4'b1000, 4'b0000, 1'b0, 1'b1, 1, 4'b1111, 4'b0000, 1'b0));
    vt.push_back(mk("t5_fack", 4'b1000, 4'b0000, 1'b0, 1'b1, 2, 4'b1111, 4'b1000, 1'b0));
    vt.push_back(mk("t5_ffall",4'b1000, 4'b0000, 1'b0, 1'b0, 1, 4'b1000, 4'b1000, 1'b0));
    vt.push_back(mk("t5_drop", 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 4'b1000, 4'b1000, 1'b0));
    vt.push_back(mk("t5_hold", 4'b0000, 4'b0000, 1'b0, 1'b0, 8, 4'b1000, 4'b0000, 1'b0));
    vt.push_back(mk("t5_off",  4'b0000, 4'b0000, 1'b0, 1'b0, 1, 4'b0000, 4'b0000, 1'b0));
    // force_on rising mid-wake: unit 0 still completes its wake count
    vt.push_back(mk("fw_grant",4'b0001, 4'b0000, 1'b0, 1'b0, 1, 4'b0000, 4'b0000, 1'b0));
    vt.push_back(mk("fw_wake", 4'b0001, 4'b0000, 1'b0, 1'b1, 2, 4'b1111, 4'b0000, 1'b1));
    vt.push_back(mk("fw_on",   4'b0001, 4'b0000, 1'b0, 1'b1, 1, 4'b1111, 4'b0001, 1'b0));
    vt.push_back(mk("fw_ffall",4'b0001, 4'b0000, 1'b0, 1'b0, 1, 4'b0001, 4'b0001, 1'b0));
    vt.push_back(mk("fw_drop", 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 4'b0001, 4'b0001, 1'b0));
    vt.push_back(mk("fw_hold", 4'b0000, 4'b0000, 1'b0, 1'b0, 8, 4'b0001, 4'b0000, 1'b0));
    vt.push_back(mk("fw_off",  4'b0000, 4'b0000, 1'b0, 1'b0, 1, 4'b0000, 4'b0000, 1'b0));

    foreach (vt[i]) begin
      for (int c = 0; c < vt[i].n; c++) begin
        drive(vt[i].req, vt[i].busy, vt[i].scan, vt[i].frc);
        #1;
        chk({vt[i].tag, "_cg"}, bus.cg_en, vt[i].cg);
        chk({vt[i].tag, "_ack"}, bus.ack, vt[i].ack);
        chk({vt[i].tag, "_wk"}, {3'b000, bus.waking}, {3'b000, vt[i].wk});
        tick();
      end
    end

    // Inrush: all four request together; wakes are serialised 0,1,2,3.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(4'b1111, 4'b0000, 1'b0, 1'b0);
      #1;
      for (int i = 0; i < N; i++) begin
        ea[i] = (k >= 3 * (i + 1));
        ec[i] = (k >= 3 * i + 1);
      end
      ew = (k % 3 != 0) && (k < 12);
      chk("inrush_ack", bus.ack, ea);
      chk("inrush_cg", bus.cg_en, ec);
      chk("inrush_wk", {3'b000, bus.waking}, {3'b000, ew});
      tick();
    end

    // Round robin: serve unit 0 alone (pointer moves to 1), then 0 and 2
    // request together repeatedly; 2 must win each paired round, giving
    // the grant order 0,2,0,2,0.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(4'b0001, 4'b0000, 1'b0, 1'b0);
      #1;
      if (k == 3) chk("rr_solo_ack", bus.ack, 4'b0001);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      drive(4'b0000, 4'b0000, 1'b0, 1'b0);
      #1;
      if (k == 9) chk("rr_solo_off", bus.cg_en, 4'b0000);
      tick();
    end
    run_pair("rr_r1", 4'b0100);
    run_pair("rr_r2", 4'b0100);

    // Reset while unit 2 is in WAKE and unit 0 in HOLD.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(4'b0001, 4'b0000, 1'b0, 1'b0);
      #1;
      if (k == 3) chk("mr_u0_ack", bus.ack, 4'b0001);
      tick();
    end
    drive(4'b0100, 4'b0000, 1'b0, 1'b0);
    #1;
    tick();
    drive(4'b0100, 4'b0000, 1'b0, 1'b0);
    rst_l = 1'b0;
    #1;
    chk("mr_pre_cg", bus.cg_en, 4'b0101);
    chk("mr_pre_wk", {3'b000, bus.waking}, 4'b0001);
    tick();
    rst_l = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    #1;
    chk("mr_post_cg", bus.cg_en, 4'b0000);
    chk("mr_post_ack", bus.ack, 4'b0000);
    chk("mr_post_wk", {3'b000, bus.waking}, 4'b0000);
    tick();
    // rr pointer restarted at 0: unit 0 beats unit 3.
    for (int k = 0; k < 2; k++) begin
      drive(4'b1001, 4'b0000, 1'b0, 1'b0);
      #1;
      if (k == 1) chk("mr_rr_restart", bus.cg_en, 4'b0001);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
